// File: rtl/instruction_mem_ram.sv
// Loadable instruction memory for the MIPS fetch stage. A program is streamed in
// over a valid/ready port and read back with one-cycle latency.
module instruction_mem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int LEN_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf,
  output logic [LEN_W-1:0]  prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] address,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              mem_end
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   wptr_reg, wptr_next;
  logic [LEN_W-1:0]   prog_len_reg, prog_len_next;
  logic               load_ovf_reg, load_ovf_next;
  logic               load_done_reg, load_done_next;
  logic               fetch_valid_reg;
  logic               mem_end_reg;
  logic [DATA_W-1:0]  instruction_reg;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               load_accept;
  logic               load_final;
  logic               fetch_accept;
  logic               in_range;
  logic [ADDR_W-1:0]  prog_len_ext;

  assign load_ready   = (state_reg == LOAD);
  assign load_accept  = load_ready && load_valid && !load_start;
  // A full buffer without load_last closes the program as if it were the last word.
  assign load_final   = load_accept && (load_last || (wptr_reg == IDX_W'(DEPTH - 1)));
  assign fetch_ready  = (state_reg == RUN) && !load_start;
  assign fetch_accept = fetch_ready && fetch_req;
  assign prog_len_ext = ADDR_W'(prog_len_reg);
  assign in_range     = (address < prog_len_ext);

  assign load_done   = load_done_reg;
  assign load_ovf    = load_ovf_reg;
  assign prog_len    = prog_len_reg;
  assign fetch_valid = fetch_valid_reg;
  assign instruction = instruction_reg;
  assign mem_end     = mem_end_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wptr_next      = wptr_reg;
    prog_len_next  = prog_len_reg;
    load_ovf_next  = load_ovf_reg;
    load_done_next = 1'b0;
    if (load_start) begin
      // A new load from any state discards the current program.
      state_next    = LOAD;
      wptr_next     = '0;
      prog_len_next = '0;
      load_ovf_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (load_final) begin
            state_next     = RUN;
            wptr_next      = '0;
            prog_len_next  = load_last ? (LEN_W'(wptr_reg) + LEN_W'(1)) : LEN_W'(DEPTH);
            load_ovf_next  = !load_last;
            load_done_next = 1'b1;
          end else if (load_accept) begin
            wptr_next = wptr_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      prog_len_reg  <= '0;
      load_ovf_reg  <= 1'b0;
      load_done_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      prog_len_reg  <= prog_len_next;
      load_ovf_reg  <= load_ovf_next;
      load_done_reg <= load_done_next;
    end
  end

  // Storage is never cleared; prog_len=0 makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && load_accept) begin
      mem[wptr_reg] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_valid_reg <= 1'b0;
      instruction_reg <= '0;
      mem_end_reg     <= 1'b1;
    end else begin
      fetch_valid_reg <= fetch_accept;
      if (fetch_accept) begin
        instruction_reg <= in_range ? mem[address[IDX_W-1:0]] : '0;
        mem_end_reg     <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_instruction_mem_ram.sv
// Randomized bench for instruction_mem_ram: loads programs, fetches them back and
// compares against an array model of the loaded program.
module tb_instruction_mem_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_ovf;
  logic [LEN_W-1:0]  prog_len;
  logic              fetch_req;
  logic [ADDR_W-1:0] address;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              mem_end;

  instruction_mem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_ovf(load_ovf), .prog_len(prog_len),
    .fetch_req(fetch_req), .address(address), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .instruction(instruction), .mem_end(mem_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the words of the committed program and its length.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_len;
  bit                model_ovf;
  logic [DATA_W-1:0] prog_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W-1:0] last_instr;
  logic              last_end;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input bit send_start, input bit with_last, input int gap_max);
    int  n;
    int  acc;
    bit  is_last;
    n   = prog_q.size();
    acc = 0;
    if (send_start) begin
      load_start = 1'b1; load_valid = 1'($urandom % 2); load_data = $urandom;
      cycle();
      load_start = 1'b0;
    end
    load_valid = 1'b0;
    checks++;
    if (prog_len !== '0 || load_ovf !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_begin: prog_len=%0d ovf=%0b ready=%0b, need 0/0/1", prog_len, load_ovf, load_ready);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        load_valid = 1'b0; load_data = $urandom; load_last = 1'($urandom % 2);
        cycle();
      end
      is_last    = with_last && (i == n - 1);
      load_valid = 1'b1; load_data = prog_q[i]; load_last = is_last;
      #1;
      if (acc == DEPTH) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_full: load_ready=%0b, need 0", load_ready);
        end
        break;
      end
      checks++;
      if (load_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: load_ready=%0b, need 1 (word %0d)", load_ready, i);
      end
      cycle();
      model_mem[acc] = prog_q[i];
      acc++;
      if (is_last || acc == DEPTH) begin
        load_valid = 1'b0; load_last = 1'b0;
        model_len = acc;
        model_ovf = !is_last;
        checks++;
        if (load_done !== 1'b1 || prog_len !== LEN_W'(model_len) || load_ovf !== model_ovf || load_ready !== 1'b0) begin
          errors++;
          $display("FAIL load_commit: done=%0b len=%0d ovf=%0b ready=%0b, need 1/%0d/%0b/0",
                   load_done, prog_len, load_ovf, load_ready, model_len, model_ovf);
        end
        $display("load committed: len=%0d ovf=%0b", model_len, model_ovf);
        cycle();
        checks++;
        if (load_done !== 1'b0) begin
          errors++;
          $display("FAIL load_done_pulse: load_done=%0b one cycle later, need 0", load_done);
        end
      end else begin
        checks++;
        if (load_done !== 1'b0) begin
          errors++;
          $display("FAIL load_done_early: load_done=%0b after word %0d, need 0", load_done, i);
        end
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch_seq();
    bit                hit;
    logic [DATA_W-1:0] exp_i;
    foreach (addr_q[k]) begin
      address = addr_q[k]; fetch_req = 1'b1;
      #1;
      checks++;
      if (fetch_ready !== 1'b1) begin
        errors++;
        $display("FAIL fetch_ready: fetch_ready=%0b, need 1", fetch_ready);
      end
      cycle();
      hit   = (addr_q[k] < model_len);
      exp_i = hit ? model_mem[int'(addr_q[k])] : '0;
      checks++;
      if (fetch_valid !== 1'b1 || instruction !== exp_i || mem_end !== !hit) begin
        errors++;
        $display("FAIL fetch_data: addr=%0h valid=%0b instr=%08h end=%0b, need 1/%08h/%0b",
                 addr_q[k], fetch_valid, instruction, mem_end, exp_i, !hit);
      end
      $display("fetch addr=%0h instr=%08h mem_end=%0b", addr_q[k], instruction, mem_end);
      last_instr = exp_i;
      last_end   = !hit;
    end
    fetch_req = 1'b0; address = ADDR_W'($urandom);
    cycle();
    checks++;
    if (fetch_valid !== 1'b0 || instruction !== last_instr || mem_end !== last_end) begin
      errors++;
      $display("FAIL fetch_hold: valid=%0b instr=%08h end=%0b, need 0/%08h/%0b",
               fetch_valid, instruction, mem_end, last_instr, last_end);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
    fetch_req = 0; address = '0;
    cycle(); cycle();
    rst_n = 1'b1; fetch_req = 1'b1; address = '0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: fetch_ready=%0b load_ready=%0b, need 0/0", fetch_ready, load_ready);
    end
    cycle();
    checks++;
    if (fetch_valid !== 1'b0 || mem_end !== 1'b1 || prog_len !== '0 || instruction !== '0 ||
        load_done !== 1'b0 || load_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b end=%0b len=%0d instr=%08h done=%0b ovf=%0b",
               fetch_valid, mem_end, prog_len, instruction, load_done, load_ovf);
    end
    fetch_req = 1'b0;
    model_len = 0;
  endtask

  task automatic test_basic_load();
    prog_q = '{32'h2001_0001, 32'h0001_1020, 32'h0C01_0001};
    load_prog(1'b1, 1'b1, 0);
    addr_q = '{30'd0, 30'd1, 30'd2, 30'd3};
    fetch_seq();
  endtask

  task automatic test_valid_gaps();
    prog_q = '{$urandom, $urandom, $urandom};
    load_prog(1'b1, 1'b1, 2);
    addr_q = '{30'd2, 30'd0, 30'd1, 30'd3, 30'd4};
    fetch_seq();
  endtask

  task automatic test_overflow();
    prog_q = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    load_prog(1'b1, 1'b0, 0);
    addr_q = '{30'h2000_0000, 30'd0, 30'd1, 30'd2, 30'd3, 30'd4, 30'h3FFF_FFFF};
    fetch_seq();
  endtask

  task automatic test_start_wins();
    load_start = 1'b1; fetch_req = 1'b1; address = '0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_wins_ready: fetch_ready=%0b, need 0", fetch_ready);
    end
    cycle();
    load_start = 1'b0; fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || prog_len !== '0 || load_ovf !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_wins_state: valid=%0b len=%0d ovf=%0b ready=%0b, need 0/0/0/1",
               fetch_valid, prog_len, load_ovf, load_ready);
    end
    model_len = 0;
    prog_q = '{$urandom};
    load_prog(1'b0, 1'b1, 0);
    addr_q = '{30'd0, 30'd1};
    fetch_seq();
  endtask

  task automatic test_restart_in_load();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    repeat (2) begin
      load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
      cycle();
    end
    load_start = 1'b1; load_valid = 1'b1; load_data = $urandom; load_last = 1'b1;
    cycle();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    checks++;
    if (load_done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: done=%0b ready=%0b, need 0/1", load_done, load_ready);
    end
    model_len = 0;
    prog_q = '{$urandom, $urandom};
    load_prog(1'b0, 1'b1, 1);
    addr_q = '{30'd0, 30'd1, 30'd2};
    fetch_seq();
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; address = '0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || mem_end !== 1'b1 || instruction !== '0 || prog_len !== '0) begin
      errors++;
      $display("FAIL reset_mid_fetch: valid=%0b end=%0b instr=%08h len=%0d, need 0/1/0/0",
               fetch_valid, mem_end, instruction, prog_len);
    end
    model_len = 0;
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    repeat (2) begin
      load_valid = 1'b1; load_data = $urandom;
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; load_valid = 1'b0;
    checks++;
    if (prog_len !== '0 || load_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_load: len=%0d ready=%0b done=%0b, need 0/0/0", prog_len, load_ready, load_done);
    end
    fetch_req = 1'b1; address = '0;
    #1;
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL refused_after_reset: fetch_ready=%0b, need 0", fetch_ready);
    end
    cycle();
    fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_result_after_reset: fetch_valid=%0b, need 0", fetch_valid);
    end
    prog_q = '{$urandom, $urandom, $urandom};
    load_prog(1'b1, 1'b1, 1);
    addr_q = '{30'd0, 30'd1, 30'd2, 30'd3};
    fetch_seq();
  endtask

  task automatic test_random();
    int n;
    bit wl;
    repeat (8) begin
      n = $urandom_range(1, DEPTH + 2);
      wl = (n < DEPTH) ? 1'b1 : 1'($urandom % 2);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back($urandom);
      load_prog(1'b1, wl, 2);
      addr_q.delete();
      for (int i = 0; i < 6; i++) addr_q.push_back(ADDR_W'($urandom_range(0, DEPTH + 1)));
      addr_q.push_back(ADDR_W'($urandom));
      fetch_seq();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_valid_gaps();
    test_overflow();
    test_start_wins();
    test_restart_in_load();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
